rotate_ctrl: RTL

- FSM controller that sequences the Keccak rho lane-rotation datapath (25-lane index counter, per-lane rotator, output lane write-back) for one full tensor pass per start request.
- Sits between the permutation top-level sequencer (start/done handshake) and the rotate datapath control pins.
- Adds a per-lane watchdog so that a stuck rotator raises an error instead of hanging the permutation.

---
 rtl/rotate_pkg.sv | 18 +
 rtl/rotate_watchdog.sv | 39 +++
 rtl/rotate_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/rotate_pkg.sv
// Shared types and constants for the Keccak rho lane-rotation controller.
package rotate_pkg;

  localparam int unsigned LANES   = 25;
  localparam int unsigned MAX_ROT = 63;
  localparam int unsigned WD_W    = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    INIT   = 3'd1,
    LOAD   = 3'd2,
    ROTATE = 3'd3,
    NEXT   = 3'd4,
    FINISH = 3'd5,
    ERROR  = 3'd6
  } state_e;

endpackage

// File: rtl/rotate_watchdog.sv
// Per-lane ROTATE cycle counter; flags the last legal rotate cycle of a lane.
module rotate_watchdog
  import rotate_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic limit_c
);

  if ((2 ** WD_W) <= (MAX_ROT + 1)) begin : g_wd_too_narrow
    $error("rotate_watchdog: WD_W too small for MAX_ROT");
  end

  logic [WD_W-1:0] wd_q;
  logic [WD_W-1:0] wd_d;

  always_comb begin
    wd_d = wd_q;
    if (clr) begin
      wd_d = '0;
    end else if (en) begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  // wd_q counts earlier rotate cycles, so this is rotate cycle MAX_ROT+1
  assign limit_c = (wd_q == WD_W'(MAX_ROT));

endmodule

// File: rtl/rotate_ctrl.sv
// Sequencer for the rho rotate datapath: one 25-lane pass per start, with a
// per-lane watchdog that parks the controller in ERROR on a stuck rotator.
module rotate_ctrl
  import rotate_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic ready,
  output logic busy,
  output logic done,
  output logic err,
  input  logic idx_last,
  input  logic ended,
  output logic idx_rst,
  output logic cnt,
  output logic r_rst,
  output logic r_ld,
  output logic c_ld,
  output logic shift,
  output logic r_cnt,
  output logic lane_we
);

  state_e     state_q, state_d;
  logic       ready_q, ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       idx_rst_q, idx_rst_d;
  logic       r_rst_q, r_rst_d;
  logic       r_ld_q, r_ld_d;
  logic       c_ld_q, c_ld_d;
  logic       lane_we_q, lane_we_d;
  logic [4:0] lane_cnt_q, lane_cnt_d;
  logic       wd_limit_c;

  rotate_watchdog u_wd (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q == LOAD),
    .en      (state_q == ROTATE),
    .limit_c (wd_limit_c)
  );

  // Next state, plus registered outputs decoded from the state being entered
  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    case (state_q)
      IDLE, ERROR: if (start) state_d = INIT;
      INIT:        state_d = LOAD;
      LOAD:        state_d = ROTATE;
      ROTATE: begin
        if (ended) begin
          state_d = NEXT;
        end else if (wd_limit_c) begin
          state_d = ERROR;
        end
      end
      NEXT:        state_d = idx_last ? FINISH : LOAD;
      FINISH:      state_d = IDLE;
      default:     state_d = IDLE;
    endcase

    if (state_q == INIT) begin
      lane_cnt_d = '0;
    end else if (state_q == NEXT) begin
      lane_cnt_d = lane_cnt_q + 5'(1);
    end

    ready_d   = (state_d == IDLE) || (state_d == ERROR);
    busy_d    = state_d inside {INIT, LOAD, ROTATE, NEXT};
    done_d    = (state_d == FINISH);
    err_d     = (state_d == ERROR);
    idx_rst_d = (state_d == INIT);
    r_rst_d   = (state_d == INIT);
    r_ld_d    = (state_d == LOAD);
    c_ld_d    = (state_d == LOAD);
    lane_we_d = (state_d == NEXT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      idx_rst_q  <= 1'b0;
      r_rst_q    <= 1'b0;
      r_ld_q     <= 1'b0;
      c_ld_q     <= 1'b0;
      lane_we_q  <= 1'b0;
      lane_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      idx_rst_q  <= idx_rst_d;
      r_rst_q    <= r_rst_d;
      r_ld_q     <= r_ld_d;
      c_ld_q     <= c_ld_d;
      lane_we_q  <= lane_we_d;
      lane_cnt_q <= lane_cnt_d;
    end
  end

  // A completed pass must have written back every lane
  always_ff @(posedge clk) begin
    if (!rst && state_q == FINISH) begin
      assert (lane_cnt_q == 5'(LANES));
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign idx_rst = idx_rst_q;
  assign r_rst   = r_rst_q;
  assign r_ld    = r_ld_q;
  assign c_ld    = c_ld_q;
  assign lane_we = lane_we_q;

  // These follow live datapath status within the current state
  assign shift = (state_q == ROTATE) && !ended;
  assign r_cnt = (state_q == ROTATE) && !ended;
  assign cnt   = (state_q == NEXT) && !idx_last;

endmodule
